seq_arith_unit: RTL

//  Parametrised sequential multiply/divide unit: one datapath, a control FSM
//  and a bit counter. Loads two operands serially from one data bus on
//  one-shot load pulses, then runs on start. Multiply is shift-add; divide is

---
 rtl/seq_arith_pkg.sv | 24 ++
 rtl/seq_arith_datapath.sv | 137 +++++++++++++
 rtl/seq_arith_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package seq_arith_pkg;

    // Control FSM states. The numeric values are part of the interface
    // and must stay fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_ARMED  = 3'd2,
        ST_RUN    = 3'd3,
        ST_SIGN   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Operation select, sampled when start is accepted.
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // True in the states where an operation is in flight.
    function automatic logic f_is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_SIGN);
    endfunction

endpackage

// File: rtl/seq_arith_datapath.sv
// Operand registers, shift-add / restoring-divide core and sign fix-up.
// Sequenced entirely by the init/step/fix/div0 strobes from the top level.
module seq_arith_datapath
    import seq_arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load_a,
    input  logic             i_load_b,
    input  logic             i_init,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic             i_div0,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_b_zero,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [WIDTH-1:0] o_result_lo
);

    // Magnitude of an operand; identity in unsigned mode. |MIN| still fits
    // in WIDTH bits when read as unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            return -v;
        end
        return v;
    endfunction

    // Conditional two's-complement negation, single width.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v,
                                               input logic en);
        return en ? -v : v;
    endfunction

    // Conditional two's-complement negation, double width.
    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v,
                                                  input logic en);
        return en ? -v : v;
    endfunction

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_p;       // product high half / partial remainder
    logic [WIDTH-1:0]   r_q;       // product low half / quotient
    logic [WIDTH-1:0]   r_m;       // |B|
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_result_hi;
    logic [WIDTH-1:0]   r_result_lo;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH+1:0]   w_trial;
    logic               w_trial_neg;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign o_b_zero    = (r_op_b == '0);
    assign o_result_hi = r_result_hi;
    assign o_result_lo = r_result_lo;

    // Arithmetic for one step plus the signed fix-up of the finished result.
    // The partial remainder after the shift needs WIDTH+1 bits, so the trial
    // subtraction carries one more bit to hold its sign.
    always_comb begin
        w_sum       = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : '0);
        w_rs        = {r_p, r_q[WIDTH-1]};
        w_trial     = {1'b0, w_rs} - {2'b00, r_m};
        w_trial_neg = w_trial[WIDTH+1];
        w_prod_fix  = f_neg2({r_p, r_q}, SIGNED && (r_sa ^ r_sb));
        w_quo_fix   = f_neg(r_q, SIGNED && (r_sa ^ r_sb));
        w_rem_fix   = f_neg(r_p, SIGNED && r_sa);
    end

    // Operand capture from the shared data bus; raw values, no sign handling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else begin
            if (i_load_a) r_op_a <= i_data;
            if (i_load_b) r_op_b <= i_data;
        end
    end

    // Iterative core: init loads magnitudes and signs, step retires one bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p  <= '0;
            r_q  <= '0;
            r_m  <= '0;
            r_sa <= 1'b0;
            r_sb <= 1'b0;
        end else if (i_init) begin
            r_p  <= '0;
            r_q  <= f_mag(r_op_a);
            r_m  <= f_mag(r_op_b);
            r_sa <= SIGNED && r_op_a[WIDTH-1];
            r_sb <= SIGNED && r_op_b[WIDTH-1];
        end else if (i_step) begin
            if (i_mode == MODE_MUL) begin
                // {carry, P, Q} >> 1 after the conditional add
                r_p <= w_sum[WIDTH:1];
                r_q <= {w_sum[0], r_q[WIDTH-1:1]};
            end else begin
                // restoring step: keep the trial only when it stays >= 0
                r_p <= w_trial_neg ? w_rs[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_q <= {r_q[WIDTH-2:0], ~w_trial_neg};
            end
        end
    end

    // Result registers: written on the sign cycle or on a divide by zero,
    // otherwise held across new operand loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result_hi <= '0;
            r_result_lo <= '0;
        end else if (i_div0) begin
            r_result_hi <= r_op_a;
            r_result_lo <= '1;
        end else if (i_fix) begin
            if (i_mode == MODE_MUL) begin
                {r_result_hi, r_result_lo} <= w_prod_fix;
            end else begin
                r_result_hi <= w_rem_fix;
                r_result_lo <= w_quo_fix;
            end
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential multiply/divide unit: control FSM and bit counter driving
// the arithmetic datapath.
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             loaded_a,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_done;
    logic             r_dbz;

    logic             w_load_a;
    logic             w_load_b;
    logic             w_init;
    logic             w_step;
    logic             w_fix;
    logic             w_div0;
    logic             w_b_zero;

    // Moore status outputs decoded from the state alone.
    assign ready       = (r_state == ST_IDLE);
    assign loaded_a    = (r_state == ST_LOAD_B);
    assign armed       = (r_state == ST_ARMED);
    assign busy        = f_is_busy(r_state);
    assign done        = r_done;
    assign div_by_zero = r_dbz;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and datapath strobes. In ARMED, start takes priority
    // over load simply because load is never looked at there.
    always_comb begin
        w_next   = r_state;
        w_load_a = 1'b0;
        w_load_b = 1'b0;
        w_init   = 1'b0;
        w_step   = 1'b0;
        w_fix    = 1'b0;
        w_div0   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_load_a = 1'b1;
                    w_next   = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (load) begin
                    w_load_b = 1'b1;
                    w_next   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    w_init = 1'b1;
                    if ((mode == MODE_DIV) && w_b_zero) begin
                        w_div0 = 1'b1;
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_fix  = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bit counter: cleared on start accept, advances once per RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_init) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Operation mode and divide-by-zero flag, both updated on start accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= MODE_MUL;
            r_dbz  <= 1'b0;
        end else if (w_init) begin
            r_mode <= mode;
            r_dbz  <= w_div0;
        end
    end

    // done is registered so it is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_next == ST_DONE);
        end
    end

    seq_arith_datapath #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .i_load_a    (w_load_a),
        .i_load_b    (w_load_b),
        .i_init      (w_init),
        .i_step      (w_step),
        .i_fix       (w_fix),
        .i_div0      (w_div0),
        .i_mode      (r_mode),
        .i_data      (data_in),
        .o_b_zero    (w_b_zero),
        .o_result_hi (result_hi),
        .o_result_lo (result_lo)
    );

endmodule
